// File: rtl/flit_link_sender.sv
// flit_link_sender: drains the show-ahead flit FIFO onto the inter-router link.
// Requests the output port, streams one packet under credit-based flow control,
// then releases the port.
// Optional feature macro: LINK_STATS_EN builds the flit/packet counters.
module flit_link_sender #(
   parameter int unsigned flit_width   = 64,
   parameter int unsigned credit_depth = 8,
   parameter int unsigned credit_width = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [flit_width-1:0]   fifo_out,
   input  logic                    fifo_empty,
   output logic                    fifo_consume,
   output logic                    alloc_req,
   input  logic                    alloc_gnt,
   output logic                    alloc_rel,
   output logic                    link_valid,
   output logic [flit_width-1:0]   link_data,
   input  logic                    credit_in,
   output logic [credit_width-1:0] credit_cnt,
   output logic                    fmt_err,
   output logic                    credit_err,
   output logic [31:0]             flit_count,
   output logic [31:0]             pkt_count
);

   typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

   localparam logic [1:0] TyBody   = 2'b00;
   localparam logic [1:0] TyHead   = 2'b01;
   localparam logic [1:0] TyTail   = 2'b10;
   localparam logic [1:0] TySingle = 2'b11;

   localparam logic [credit_width-1:0] CreditMax = credit_width'(credit_depth);

   state_e                  state_q, state_d;
   logic                    first_q, first_d;
   logic                    drop, send;
   logic                    fmt_err_d, credit_err_d;
   logic                    alloc_req_d, alloc_rel_d;
   logic [credit_width-1:0] credit_d;
   logic [1:0]              head_ty;
   logic                    head_is_end;

   assign head_ty     = fifo_out[flit_width-1:flit_width-2];
   assign head_is_end = (head_ty == TyTail) || (head_ty == TySingle);

   assign send         = (state_q == StXfer) && !fifo_empty && (credit_cnt != '0);
   // Gated by reset so nothing is popped while the block is held in reset.
   assign fifo_consume = (send || drop) && rst;

   // Next-state logic, orphan drop, framing checks and port request/release.
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      drop        = 1'b0;
      fmt_err_d   = fmt_err;
      alloc_rel_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               if ((head_ty == TyHead) || (head_ty == TySingle)) begin
                  state_d = StReq;
               end else begin
                  // Orphan body/tail: discard without sending.
                  drop      = 1'b1;
                  fmt_err_d = 1'b1;
               end
            end
         end
         StReq: begin
            if (alloc_gnt) begin
               state_d = StXfer;
               first_d = 1'b1;
            end
         end
         StXfer: begin
            if (send) begin
               first_d = 1'b0;
               if ((head_ty == TyHead) && !first_q) begin
                  fmt_err_d = 1'b1;
               end
               if (head_is_end) begin
                  state_d     = StIdle;
                  alloc_rel_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      alloc_req_d = (state_d == StReq);
   end

   // Credit counter update with overflow detection.
   always_comb begin
      credit_d     = credit_cnt;
      credit_err_d = credit_err;
      if (send && !credit_in) begin
         credit_d = credit_cnt - 1'b1;
      end else if (credit_in && !send) begin
         if (credit_cnt == CreditMax) begin
            credit_err_d = 1'b1;
         end else begin
            credit_d = credit_cnt + 1'b1;
         end
      end
   end

   // State, control outputs, credits and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         first_q    <= 1'b0;
         alloc_req  <= 1'b0;
         alloc_rel  <= 1'b0;
         credit_cnt <= CreditMax;
         fmt_err    <= 1'b0;
         credit_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         alloc_req  <= alloc_req_d;
         alloc_rel  <= alloc_rel_d;
         credit_cnt <= credit_d;
         fmt_err    <= fmt_err_d;
         credit_err <= credit_err_d;
      end
   end

   // Link output register: one-cycle latency from FIFO head, data holds when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         link_valid <= 1'b0;
         link_data  <= '0;
      end else begin
         link_valid <= send;
         if (send) begin
            link_data <= fifo_out;
         end
      end
   end

`ifdef LINK_STATS_EN
   logic [31:0] flit_q, pkt_q;

   // Sent-flit and sent-packet counters, free-running with natural wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flit_q <= '0;
         pkt_q  <= '0;
      end else if (send) begin
         flit_q <= flit_q + 32'd1;
         if (head_is_end) begin
            pkt_q <= pkt_q + 32'd1;
         end
      end
   end

   assign flit_count = flit_q;
   assign pkt_count  = pkt_q;
`else
   assign flit_count = 32'd0;
   assign pkt_count  = 32'd0;
`endif

endmodule

// File: tb/tb_flit_link_sender.sv
// Self-checking bench for flit_link_sender: table-driven packet scenarios plus
// hand-written reset, credit-stall, credit-overflow and statistics sequences.
module tb_flit_link_sender;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] fifo_out;
   logic        fifo_empty;
   logic        fifo_consume;
   logic        alloc_req;
   logic        alloc_gnt = 1'b0;
   logic        alloc_rel;
   logic        link_valid;
   logic [63:0] link_data;
   logic        credit_in = 1'b0;
   logic [3:0]  credit_cnt;
   logic        fmt_err;
   logic        credit_err;
   logic [31:0] flit_count;
   logic [31:0] pkt_count;

   int checks = 0;
   int errors = 0;

   // Show-ahead FIFO model: bench pushes, DUT pops.
   logic [63:0] mem [64];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_out   = mem[rd_ptr[5:0]];

   // Monitor totals, sampled 1 time unit after the rising edge.
   logic [63:0] log_mem [256];
   int          sent_total = 0;
   int          rel_total  = 0;
   int          req_total  = 0;

   flit_link_sender dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_out     (fifo_out),
      .fifo_empty   (fifo_empty),
      .fifo_consume (fifo_consume),
      .alloc_req    (alloc_req),
      .alloc_gnt    (alloc_gnt),
      .alloc_rel    (alloc_rel),
      .link_valid   (link_valid),
      .link_data    (link_data),
      .credit_in    (credit_in),
      .credit_cnt   (credit_cnt),
      .fmt_err      (fmt_err),
      .credit_err   (credit_err),
      .flit_count   (flit_count),
      .pkt_count    (pkt_count)
   );

   always #5 clk = ~clk;

   // FIFO pop.
   always @(posedge clk) begin
      if (fifo_consume) rd_ptr <= rd_ptr + 1;
   end

   // Monitor of link flits, release pulses and request cycles.
   always @(posedge clk) begin
      #1;
      if (link_valid) begin
         log_mem[sent_total[7:0]] = link_data;
         sent_total = sent_total + 1;
      end
      if (alloc_rel) rel_total = rel_total + 1;
      if (alloc_req) req_total = req_total + 1;
   end

   // Allocator model: grants one cycle after seeing a request.
   always @(negedge clk) begin
      alloc_gnt = alloc_req;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [1:0] t, input int p);
      return {t, 62'(p)};
   endfunction

   task automatic push(input logic [63:0] f);
      mem[wr_ptr[5:0]] = f;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      wr_ptr = rd_ptr;
      rst = 1'b1;
   endtask

   typedef struct {
      int             n;
      logic [3:0][1:0] ty;
      logic [3:0]     sent_mask;
      int             exp_sent;
      logic [3:0]     exp_credit;
      logic           exp_fmt;
      int             exp_rel;
      logic           exp_req;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int base_s, base_r, base_q, k, idx;
      bit found;

      // ty[0] is the first flit pushed.
      vecs[0] = '{4, {2'b10, 2'b00, 2'b00, 2'b01}, 4'b1111, 4, 4'd4, 1'b0, 1, 1'b1};
      vecs[1] = '{1, {2'b00, 2'b00, 2'b00, 2'b11}, 4'b0001, 1, 4'd7, 1'b0, 1, 1'b1};
      vecs[2] = '{1, {2'b00, 2'b00, 2'b00, 2'b00}, 4'b0000, 0, 4'd8, 1'b1, 0, 1'b0};
      vecs[3] = '{2, {2'b00, 2'b00, 2'b11, 2'b10}, 4'b0010, 1, 4'd7, 1'b1, 1, 1'b1};
      vecs[4] = '{3, {2'b00, 2'b10, 2'b01, 2'b01}, 4'b0111, 3, 4'd5, 1'b1, 1, 1'b1};
      vecs[5] = '{2, {2'b00, 2'b00, 2'b11, 2'b11}, 4'b0011, 2, 4'd6, 1'b0, 2, 1'b1};

      // Reset state.
      do_reset();
      #1;
      chk("rst_link_valid", 64'(link_valid), 64'd0);
      chk("rst_link_data", link_data, 64'd0);
      chk("rst_alloc_req", 64'(alloc_req), 64'd0);
      chk("rst_alloc_rel", 64'(alloc_rel), 64'd0);
      chk("rst_credit", 64'(credit_cnt), 64'd8);
      chk("rst_fmt_err", 64'(fmt_err), 64'd0);
      chk("rst_credit_err", 64'(credit_err), 64'd0);
      chk("rst_flit_count", 64'(flit_count), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);

      // Table-driven packet scenarios.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         base_s = sent_total;
         base_r = rel_total;
         base_q = req_total;
         for (int i = 0; i < vecs[v].n; i++) push(mk(vecs[v].ty[i], v * 16 + i));
         repeat (20) @(negedge clk);
         chk($sformatf("v%0d_sent", v), 64'(sent_total - base_s), 64'(vecs[v].exp_sent));
         k = 0;
         for (int i = 0; i < vecs[v].n; i++) begin
            if (vecs[v].sent_mask[i]) begin
               idx = base_s + k;
               chk($sformatf("v%0d_data%0d", v, k), log_mem[idx[7:0]],
                   mk(vecs[v].ty[i], v * 16 + i));
               k = k + 1;
            end
         end
         chk($sformatf("v%0d_credit", v), 64'(credit_cnt), 64'(vecs[v].exp_credit));
         chk($sformatf("v%0d_fmt_err", v), 64'(fmt_err), 64'(vecs[v].exp_fmt));
         chk($sformatf("v%0d_rel", v), 64'(rel_total - base_r), 64'(vecs[v].exp_rel));
         chk($sformatf("v%0d_req_seen", v), 64'(req_total != base_q), 64'(vecs[v].exp_req));
         chk($sformatf("v%0d_fifo_empty", v), 64'(fifo_empty), 64'd1);
         chk($sformatf("v%0d_credit_err", v), 64'(credit_err), 64'd0);
      end

      // Asynchronous reset in the middle of a packet.
      do_reset();
      push(mk(2'b01, 1)); push(mk(2'b00, 2)); push(mk(2'b00, 3)); push(mk(2'b10, 4));
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (link_valid) found = 1'b1;
      end
      chk("mid_xfer_reached", 64'(found), 64'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_link_valid", 64'(link_valid), 64'd0);
      chk("mid_rst_alloc_req", 64'(alloc_req), 64'd0);
      chk("mid_rst_credit", 64'(credit_cnt), 64'd8);
      chk("mid_rst_consume", 64'(fifo_consume), 64'd0);
      @(negedge clk);
      wr_ptr = rd_ptr;
      push(mk(2'b00, 9));
      #1;
      chk("rst_orphan_no_pop", 64'(fifo_consume), 64'd0);
      wr_ptr = rd_ptr;
      rst = 1'b1;
      base_s = sent_total;
      base_q = req_total;
      repeat (5) @(negedge clk);
      chk("post_rst_idle_sent", 64'(sent_total - base_s), 64'd0);
      chk("post_rst_idle_req", 64'(req_total - base_q), 64'd0);

      // Credit stall on a 10-flit packet.
      do_reset();
      base_s = sent_total;
      base_r = rel_total;
      push(mk(2'b01, 100));
      for (int i = 1; i < 9; i++) push(mk(2'b00, 100 + i));
      push(mk(2'b10, 109));
      repeat (30) @(negedge clk);
      chk("stall_sent8", 64'(sent_total - base_s), 64'd8);
      chk("stall_credit0", 64'(credit_cnt), 64'd0);
      chk("stall_fifo_left", 64'(fifo_empty), 64'd0);
      chk("stall_port_held", 64'(rel_total - base_r), 64'd0);
      credit_in = 1'b1;
      @(negedge clk);
      credit_in = 1'b0;
      repeat (5) @(negedge clk);
      chk("stall_sent9", 64'(sent_total - base_s), 64'd9);
      idx = base_s + 8;
      chk("stall_data9", log_mem[idx[7:0]], mk(2'b00, 108));
      chk("stall_credit0b", 64'(credit_cnt), 64'd0);
      credit_in = 1'b1;
      @(negedge clk);
      chk("stall_credit1", 64'(credit_cnt), 64'd1);
      @(negedge clk);
      chk("both_credit_same", 64'(credit_cnt), 64'd1);
      chk("both_sent10", 64'(sent_total - base_s), 64'd10);
      credit_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("stall_credit_final", 64'(credit_cnt), 64'd1);
      chk("stall_rel", 64'(rel_total - base_r), 64'd1);
      chk("stall_fifo_empty", 64'(fifo_empty), 64'd1);

      // Credit return while already full.
      do_reset();
      credit_in = 1'b1;
      @(negedge clk);
      credit_in = 1'b0;
      chk("ovf_credit", 64'(credit_cnt), 64'd8);
      chk("ovf_err", 64'(credit_err), 64'd1);
      repeat (3) @(negedge clk);
      chk("ovf_err_sticky", 64'(credit_err), 64'd1);
      do_reset();
      #1;
      chk("ovf_err_cleared", 64'(credit_err), 64'd0);

      // Statistics: three singles plus one 4-flit packet.
      do_reset();
      push(mk(2'b11, 200)); push(mk(2'b11, 201)); push(mk(2'b11, 202));
      push(mk(2'b01, 203)); push(mk(2'b00, 204)); push(mk(2'b00, 205)); push(mk(2'b10, 206));
      repeat (40) @(negedge clk);
      chk("stats_fifo_empty", 64'(fifo_empty), 64'd1);
`ifdef LINK_STATS_EN
      chk("stats_flit_count", 64'(flit_count), 64'd7);
      chk("stats_pkt_count", 64'(pkt_count), 64'd4);
`else
      chk("stats_flit_count", 64'(flit_count), 64'd0);
      chk("stats_pkt_count", 64'(pkt_count), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
